// File: rtl/img2col_pkg.sv
// Shared parameters, state encoding and sideband tag for the img2col pixel path.
package img2col_pkg;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int K      = 5;
    localparam int N_PU   = 28;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    typedef struct packed {
        logic [5:0] pu_sel;
        logic [2:0] slot;
        logic [2:0] col;
        logic [5:0] img_row;
    } pix_tag_t;

    // Constant-K modulo by repeated subtraction; 12 steps cover any 6-bit value.
    function automatic logic [2:0] mod_k(input logic [5:0] v);
        logic [5:0] r;
        r = v;
        for (int i = 0; i < 12; i++) begin
            if (r >= 6'(K)) r = r - 6'(K);
        end
        return r[2:0];
    endfunction

endpackage

// File: rtl/img2col_addr_gen.sv
// Combinational tuple decode: image row, window slot, SRAM address and range flag.
module img2col_addr_gen
    import img2col_pkg::*;
(
    input  logic              working,
    input  logic [5:0]        round,
    input  logic [5:0]        pu1_add,
    input  logic [5:0]        pu_no,
    input  logic [5:0]        row_no,
    output logic [5:0]        img_row,
    output logic [2:0]        slot,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    localparam int AW1 = ADDR_W + 1;

    // One extra row bit so a large round cannot wrap back into range.
    logic [6:0]     row_ext;
    logic [AW1-1:0] addr_ext;

    always_comb begin
        if (working) row_ext = {1'b0, round} + 7'(K - 1);
        else         row_ext = {1'b0, row_no};
        img_row  = row_ext[5:0];
        slot     = working ? mod_k(row_ext[5:0]) : row_no[2:0];
        addr_ext = AW1'(row_ext[5:0]) * AW1'(IMG_W) + AW1'(pu_no) + AW1'(pu1_add);
        addr     = addr_ext[ADDR_W-1:0];
        in_range = (row_ext < 7'(IMG_H)) && (pu_no < 6'(N_PU)) && (pu1_add < 6'(K));
    end

endmodule

// File: rtl/img2col_pixel_feeder.sv
// Turns img2col index tuples into image-SRAM reads and aligned PU window writes.
//   state  | meaning
//   IDLE   | waiting for start, tuples ignored
//   FILL   | buffering phase, first K rows loaded into windows
//   STREAM | working phase, one new row per round
//   DONE   | last image row delivered, frame_done high
module img2col_pixel_feeder
    import img2col_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              map_valid,
    input  logic              map_working,
    input  logic [5:0]        map_round,
    input  logic [5:0]        map_pu1_add,
    input  logic [5:0]        map_pu_no,
    input  logic [5:0]        map_row_no,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_rd_addr,
    input  logic [DATA_W-1:0] img_rd_data,
    output logic              pu_wr_en,
    output logic [5:0]        pu_sel,
    output logic [2:0]        pu_slot,
    output logic [2:0]        pu_col,
    output logic [DATA_W-1:0] pu_data,
    output logic              row_done,
    output logic [5:0]        row_idx,
    output logic              frame_done
);

    feeder_state_t     state, state_nxt;
    logic [5:0]        ag_row;
    logic [2:0]        ag_slot;
    logic [ADDR_W-1:0] ag_addr;
    logic              ag_in_range;
    pix_tag_t          tag1, tag2;
    logic              wr_q;
    logic              active, last_row, accept, issue;

    img2col_addr_gen u_addr_gen (
        .working  (map_working),
        .round    (map_round),
        .pu1_add  (map_pu1_add),
        .pu_no    (map_pu_no),
        .row_no   (map_row_no),
        .img_row  (ag_row),
        .slot     (ag_slot),
        .addr     (ag_addr),
        .in_range (ag_in_range)
    );

    assign active   = (state == FILL) || (state == STREAM);
    assign row_done = wr_q && (tag2.pu_sel == 6'(N_PU - 1)) && (tag2.col == 3'(K - 1));
    assign last_row = row_done && (tag2.img_row == 6'(IMG_H - 1)) && (state == STREAM);
    // The cycle that completes the frame refuses new tuples.
    assign accept   = map_valid && active && !last_row;
    assign issue    = accept && ag_in_range;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (accept && map_working) state_nxt = STREAM;
            STREAM:  if (last_row) state_nxt = DONE;
            DONE:    if (start) state_nxt = FILL;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            img_rd_en   <= 1'b0;
            img_rd_addr <= '0;
            tag1        <= '0;
            wr_q        <= 1'b0;
            tag2        <= '0;
        end else begin
            state     <= state_nxt;
            img_rd_en <= issue;
            if (issue) begin
                img_rd_addr <= ag_addr;
                tag1        <= '{pu_sel: map_pu_no, slot: ag_slot,
                                 col: map_pu1_add[2:0], img_row: ag_row};
            end
            wr_q <= img_rd_en;
            if (img_rd_en) tag2 <= tag1;
        end
    end

    assign pu_wr_en   = wr_q;
    assign pu_sel     = tag2.pu_sel;
    assign pu_slot    = tag2.slot;
    assign pu_col     = tag2.col;
    assign pu_data    = wr_q ? img_rd_data : '0;
    assign row_idx    = row_done ? tag2.img_row : 6'd0;
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_img2col_pixel_feeder.sv
// Directed bench for img2col_pixel_feeder with a one-cycle-latency SRAM model.
module tb_img2col_pixel_feeder;
    import img2col_pkg::*;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic              map_valid = 1'b0;
    logic              map_working = 1'b0;
    logic [5:0]        map_round = '0;
    logic [5:0]        map_pu1_add = '0;
    logic [5:0]        map_pu_no = '0;
    logic [5:0]        map_row_no = '0;
    logic              img_rd_en;
    logic [ADDR_W-1:0] img_rd_addr;
    logic [DATA_W-1:0] img_rd_data = '0;
    logic              pu_wr_en;
    logic [5:0]        pu_sel;
    logic [2:0]        pu_slot;
    logic [2:0]        pu_col;
    logic [DATA_W-1:0] pu_data;
    logic              row_done;
    logic [5:0]        row_idx;
    logic              frame_done;

    int n_chk = 0;
    int n_fail = 0;

    img2col_pixel_feeder dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .map_valid   (map_valid),
        .map_working (map_working),
        .map_round   (map_round),
        .map_pu1_add (map_pu1_add),
        .map_pu_no   (map_pu_no),
        .map_row_no  (map_row_no),
        .img_rd_en   (img_rd_en),
        .img_rd_addr (img_rd_addr),
        .img_rd_data (img_rd_data),
        .pu_wr_en    (pu_wr_en),
        .pu_sel      (pu_sel),
        .pu_slot     (pu_slot),
        .pu_col      (pu_col),
        .pu_data     (pu_data),
        .row_done    (row_done),
        .row_idx     (row_idx),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [9:0] a);
        return a[7:0] ^ {a[9:8], 6'h2A};
    endfunction

    always @(posedge clk) if (img_rd_en) img_rd_data <= pix(img_rd_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tuple(input logic w, input logic [5:0] rnd, input logic [5:0] add,
                         input logic [5:0] pu, input logic [5:0] row);
        map_working = w;
        map_round   = rnd;
        map_pu1_add = add;
        map_pu_no   = pu;
        map_row_no  = row;
        map_valid   = 1'b1;
    endtask

    int wr_cnt, gap_cnt, rd_cnt, rd_j;
    logic [5:0] rd_sel, rd_idx;
    logic [2:0] rd_col;

    initial begin
        tick(); tick();
        nrst = 1'b1;
        tick();
        chk("rst_rd_en", img_rd_en, 0);
        chk("rst_wr_en", pu_wr_en, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_row_done", row_done, 0);

        // reset in the middle of a read
        start = 1'b1; tick(); start = 1'b0;
        tuple(0, 0, 2, 3, 1); tick(); map_valid = 1'b0;
        chk("t1_rd_before_rst", img_rd_en, 1);
        nrst = 1'b0; #1;
        chk("t1_rst_rd_en", img_rd_en, 0);
        chk("t1_rst_addr", img_rd_addr, 0);
        chk("t1_rst_sel", pu_sel, 0);
        chk("t1_rst_data", pu_data, 0);
        tick(); chk("t1_rst_wr0", pu_wr_en, 0);
        tick(); chk("t1_rst_wr1", pu_wr_en, 0);
        nrst = 1'b1;
        tuple(0, 0, 2, 3, 1); tick();
        chk("t1_idle_rd", img_rd_en, 0);
        tick();
        chk("t1_idle_wr", pu_wr_en, 0);
        chk("t1_idle_rd2", img_rd_en, 0);
        map_valid = 1'b0;

        // buffering address
        start = 1'b1; tick(); start = 1'b0;
        tuple(0, 0, 2, 3, 1); tick(); map_valid = 1'b0;
        chk("t2_rd_en", img_rd_en, 1);
        chk("t2_addr", img_rd_addr, 37);
        chk("t2_wr_early", pu_wr_en, 0);
        tick();
        chk("t2_wr_en", pu_wr_en, 1);
        chk("t2_sel", pu_sel, 3);
        chk("t2_slot", pu_slot, 1);
        chk("t2_col", pu_col, 2);
        chk("t2_data", pu_data, pix(10'd37));
        tick();
        chk("t2_wr_off", pu_wr_en, 0);

        // full row 0 back-to-back
        wr_cnt = 0; gap_cnt = 0; rd_cnt = 0; rd_j = -1;
        rd_sel = '0; rd_col = '0; rd_idx = '1;
        for (int j = 0; j < 142; j++) begin
            if (j < 140) tuple(0, 0, 6'(j % 5), 6'(j / 5), 0);
            else map_valid = 1'b0;
            tick();
            if (pu_wr_en) wr_cnt++;
            if ((j >= 1 && j <= 140) != pu_wr_en) gap_cnt++;
            if (row_done) begin
                rd_cnt++; rd_j = j; rd_sel = pu_sel; rd_col = pu_col; rd_idx = row_idx;
            end
        end
        chk("t4_wr_count", wr_cnt, 140);
        chk("t4_wr_gaps", gap_cnt, 0);
        chk("t4_row_done_count", rd_cnt, 1);
        chk("t4_row_done_cycle", rd_j, 140);
        chk("t4_row_done_sel", rd_sel, 27);
        chk("t4_row_done_col", rd_col, 4);
        chk("t4_row_idx", rd_idx, 0);

        // working phase with circular slot
        tuple(1, 2, 0, 0, 0); tick();
        chk("t3_rd_en_a", img_rd_en, 1);
        chk("t3_addr_a", img_rd_addr, 192);
        tuple(1, 0, 0, 0, 0); tick(); map_valid = 1'b0;
        chk("t3_wr_a", pu_wr_en, 1);
        chk("t3_slot_a", pu_slot, 1);
        chk("t3_data_a", pu_data, pix(10'd192));
        chk("t3_addr_b", img_rd_addr, 128);
        tick();
        chk("t3_slot_b", pu_slot, 4);
        chk("t3_data_b", pu_data, pix(10'd128));
        chk("t3_row_done_b", row_done, 0);
        tick();

        // out-of-range tuples
        tuple(1, 28, 0, 0, 0); tick();
        chk("t5_row_rd", img_rd_en, 0);
        tuple(1, 0, 5, 0, 0); tick();
        chk("t5_add_rd", img_rd_en, 0);
        chk("t5_row_wr", pu_wr_en, 0);
        tuple(1, 0, 0, 28, 0); tick(); map_valid = 1'b0;
        chk("t5_pu_rd", img_rd_en, 0);
        chk("t5_add_wr", pu_wr_en, 0);
        tick();
        chk("t5_pu_wr", pu_wr_en, 0);

        // last row of the frame
        tuple(1, 27, 4, 27, 0); tick();
        chk("t6_rd_last", img_rd_en, 1);
        chk("t6_addr_last", img_rd_addr, 1023);
        tuple(1, 0, 0, 0, 0);
        tick();
        chk("t6_row_done", row_done, 1);
        chk("t6_row_idx", row_idx, 31);
        chk("t6_data_last", pu_data, pix(10'd1023));
        chk("t6_frame_done_early", frame_done, 0);
        chk("t6_rd_follow", img_rd_en, 1);
        tick();
        chk("t6_frame_done", frame_done, 1);
        chk("t6_drop_at_done", img_rd_en, 0);
        chk("t6_drain_wr", pu_wr_en, 1);
        chk("t6_row_done_off", row_done, 0);
        tick();
        chk("t6_done_ignore_rd", img_rd_en, 0);
        chk("t6_done_ignore_wr", pu_wr_en, 0);
        map_valid = 1'b0;

        // restart
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_restart_fd", frame_done, 0);
        tuple(0, 0, 0, 0, 2); tick(); map_valid = 1'b0;
        chk("t6_restart_rd", img_rd_en, 1);
        chk("t6_restart_addr", img_rd_addr, 64);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
